// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared constants for the accelerator SRAM port
package sram_ctrl_pkg;
    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 32;
    localparam int ID_W = 2;
    typedef logic [1:0] bank_t;
    typedef logic [ID_W-1:0] req_id_t;
    localparam bank_t BANK_FEAT = 2'd0;
    localparam bank_t BANK_AUX = 2'd1;
    localparam bank_t BANK_WGT = 2'd2;
    localparam bank_t BANK_ILL = 2'd3;
    localparam req_id_t REQ_LOADER = 2'd0;
    localparam req_id_t REQ_CONV = 2'd1;
    localparam req_id_t REQ_WLOAD = 2'd2;
endpackage

// File: rtl/rr_arbiter3.sv
// rr_arbiter3: three-way round-robin pick, searching from ptr upward mod 3
module rr_arbiter3 (
    input  logic [2:0] valid,
    input  logic [1:0] ptr,
    output logic [2:0] grant,
    output logic [1:0] id
);
    logic [1:0] p1, p2;
    assign p1 = ptr == 2'd2 ? 2'd0 : ptr + 2'd1;
    assign p2 = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
    assign id = valid[ptr] ? ptr : valid[p1] ? p1 : p2;
    assign grant = |valid ? 3'b001 << id : 3'b000;
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin share of one SRAM port among three requesters,
// registered SRAM drive and a two-stage tag pipeline for read returns
module sram_port_arbiter #(
    parameter int NREQ = 3,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       CK,
    input  logic                       RST,
    input  logic                       arb_en,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0]            req_we,
    input  logic [2*NREQ-1:0]          req_bank,
    input  logic [ADDR_WIDTH*NREQ-1:0] req_addr,
    input  logic [DATA_WIDTH*NREQ-1:0] req_wdata,
    output logic                       rsp_valid,
    output logic [1:0]                 rsp_id,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic                       err_bank,
    output logic                       busy,
    output logic                       sram_csn,
    output logic [3:0]                 sram_wen,
    output logic [ADDR_WIDTH-1:0]      sram_addr,
    output logic [DATA_WIDTH-1:0]      sram_din,
    input  logic [DATA_WIDTH-1:0]      sram_dout
);
    import sram_ctrl_pkg::*;
    logic [NREQ-1:0] grant;
    req_id_t id, p, t1_id, t2_id;
    bank_t bank;
    logic hs, we, t1_v, t2_v;
    rr_arbiter3 u_arb (.valid(req_valid), .ptr(p), .grant(grant), .id(id));
    assign req_ready = arb_en && !RST ? grant : '0;
    assign hs = |req_ready;
    assign we = req_we[id];
    assign bank = req_bank[int'(id)*2 +: 2];
    assign rsp_valid = t2_v;
    assign rsp_id = t2_id;
    assign rsp_data = sram_dout;
    assign busy = !sram_csn || t1_v || t2_v;
    always_ff @(posedge CK or posedge RST)
        if (RST) begin
            p <= REQ_LOADER;
            sram_csn <= 1'b1;
            sram_wen <= 4'hF;
            sram_addr <= '0;
            sram_din <= '0;
            err_bank <= 1'b0;
            t1_v <= 1'b0;
            t2_v <= 1'b0;
            t1_id <= '0;
            t2_id <= '0;
        end else begin
            p <= hs ? (id == REQ_WLOAD ? REQ_LOADER : id + 2'd1) : p;
            sram_csn <= !hs;
            // bank 3 writes still select the SRAM but strobe no bank
            sram_wen <= hs && we && bank != BANK_ILL ? ~(4'b0001 << bank) : 4'hF;
            sram_addr <= hs ? req_addr[int'(id)*ADDR_WIDTH +: ADDR_WIDTH] : sram_addr;
            sram_din <= hs ? req_wdata[int'(id)*DATA_WIDTH +: DATA_WIDTH] : sram_din;
            err_bank <= hs && we && bank == BANK_ILL;
            t1_v <= hs && !we;
            t1_id <= id;
            t2_v <= t1_v;
            t2_id <= t1_id;
        end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: table, directed and random checks against a queue-based port model
module tb_sram_port_arbiter;
    logic CK = 0, RST = 0, arb_en = 0;
    logic [2:0] req_valid = 0, req_we = 0, req_ready;
    logic [5:0] req_bank = 0;
    logic [35:0] req_addr = 0;
    logic [95:0] req_wdata = 0;
    logic rsp_valid, err_bank, busy, sram_csn;
    logic [1:0] rsp_id;
    logic [31:0] rsp_data, sram_din;
    logic [31:0] sram_dout = 0;
    logic [3:0] sram_wen;
    logic [11:0] sram_addr;
    bit [31:0] mem [3][4096];
    bit [31:0] mm [3][4096];
    typedef struct {int due; logic [1:0] id; logic [31:0] data;} rd_t;
    rd_t q[$];
    typedef struct {logic en; logic [2:0] v; logic [2:0] ready;} vec_t;
    vec_t tbl[11];
    int checks = 0, failures = 0, n = 0, mp = 0;
    logic e_csn, e_err;
    logic [3:0] e_wen;
    logic [11:0] e_addr;
    logic [31:0] e_din;

    always #5 CK = ~CK;

    sram_port_arbiter dut (
        .CK(CK), .RST(RST), .arb_en(arb_en), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_bank(req_bank), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .err_bank(err_bank),
        .busy(busy), .sram_csn(sram_csn), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    // SRAM behaviour: per-bank write strobes, registered read from bank 0 only
    always @(posedge CK)
        if (!sram_csn) begin
            for (int b = 0; b < 3; b++)
                if (!sram_wen[b]) mem[b][sram_addr] <= sram_din;
            if (&sram_wen) sram_dout <= mem[0][sram_addr];
        end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic w, input logic [1:0] b, input logic [11:0] a, input logic [31:0] d);
        req_valid[i] = 1'b1;
        req_we[i] = w;
        req_bank[i*2 +: 2] = b;
        req_addr[i*12 +: 12] = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    // one clock: predict the grant from the rules, update the model, check registered outputs after the edge
    task automatic step();
        int gid, b;
        logic [2:0] er;
        logic ev;
        #2;
        gid = -1;
        for (int k = 0; k < 3; k++)
            if (gid < 0 && req_valid[(mp + k) % 3]) gid = (mp + k) % 3;
        er = (arb_en && gid >= 0) ? 3'(1 << gid) : 3'b000;
        chk("req_ready", req_ready, er);
        e_err = 0;
        if (er != 0) begin
            e_csn = 0;
            e_addr = req_addr[gid*12 +: 12];
            e_din = req_wdata[gid*32 +: 32];
            b = int'(req_bank[gid*2 +: 2]);
            mp = (gid + 1) % 3;
            if (req_we[gid]) begin
                e_wen = b < 3 ? 4'hF & ~(4'(1) << b) : 4'hF;
                e_err = (b == 3);
                if (b < 3) mm[b][e_addr] = e_din;
            end else begin
                e_wen = 4'hF;
                q.push_back('{n + 2, 2'(gid), mm[0][e_addr]});
            end
        end else begin
            e_csn = 1;
            e_wen = 4'hF;
        end
        @(posedge CK);
        n++;
        #1;
        chk("sram_csn", sram_csn, e_csn);
        chk("sram_wen", sram_wen, e_wen);
        chk("sram_addr", sram_addr, e_addr);
        chk("sram_din", sram_din, e_din);
        chk("err_bank", err_bank, e_err);
        ev = q.size() > 0 && q[0].due == n;
        chk("busy", busy, !e_csn || ev);
        chk("rsp_valid", rsp_valid, ev);
        if (ev) begin
            chk("rsp_id", rsp_id, q[0].id);
            chk("rsp_data", rsp_data, q[0].data);
            void'(q.pop_front());
        end
    endtask

    task automatic do_reset();
        arb_en = 1;
        req_valid = 3'b111;
        RST = 1;
        #3;
        q.delete();
        mp = 0;
        e_csn = 1;
        e_wen = 4'hF;
        e_addr = 0;
        e_din = 0;
        e_err = 0;
        chk("rst_ready", req_ready, 3'b000);
        chk("rst_csn", sram_csn, 1'b1);
        chk("rst_wen", sram_wen, 4'hF);
        chk("rst_addr", sram_addr, 12'h000);
        chk("rst_din", sram_din, 32'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_id", rsp_id, 2'd0);
        chk("rst_err", err_bank, 1'b0);
        chk("rst_busy", busy, 1'b0);
        req_valid = 0;
        @(posedge CK);
        #1;
        RST = 0;
    endtask

    initial begin
        tbl[0] = '{1, 3'b111, 3'b001};
        tbl[1] = '{1, 3'b111, 3'b010};
        tbl[2] = '{1, 3'b111, 3'b100};
        tbl[3] = '{1, 3'b111, 3'b001};
        tbl[4] = '{1, 3'b111, 3'b010};
        tbl[5] = '{1, 3'b111, 3'b100};
        tbl[6] = '{0, 3'b111, 3'b000};
        tbl[7] = '{1, 3'b110, 3'b010};
        tbl[8] = '{1, 3'b011, 3'b001};
        tbl[9] = '{1, 3'b101, 3'b100};
        tbl[10] = '{1, 3'b000, 3'b000};
        @(posedge CK);
        #1;
        do_reset();
        step();
        // write to bank 2, then a bank-0 read of the same address sees the untouched bank
        req_valid = 0;
        set_req(2, 1, 2, 12'h010, 32'hDEADBEEF);
        step();
        chk("wen_bank2", sram_wen, 4'b1011);
        req_valid = 0;
        set_req(1, 0, 0, 12'h010, 32'h0);
        step();
        req_valid = 0;
        step();
        chk("rd_bank0_valid", rsp_valid, 1'b1);
        chk("rd_bank0_data", rsp_data, 32'h0);
        // write then read on consecutive accepts
        set_req(0, 1, 0, 12'hA8F, 32'h12345678);
        step();
        req_valid = 0;
        set_req(1, 0, 0, 12'hA8F, 32'h0);
        step();
        req_valid = 0;
        step();
        chk("wr_rd_valid", rsp_valid, 1'b1);
        chk("wr_rd_id", rsp_id, 2'd1);
        chk("wr_rd_data", rsp_data, 32'h12345678);
        // illegal bank write stores nothing
        set_req(0, 1, 3, 12'hA8F, 32'h0BADF00D);
        step();
        chk("ill_err", err_bank, 1'b1);
        chk("ill_wen", sram_wen, 4'hF);
        req_valid = 0;
        set_req(0, 0, 1, 12'hA8F, 32'h0);
        step();
        chk("ill_err_clear", err_bank, 1'b0);
        req_valid = 0;
        step();
        chk("ill_keep_data", rsp_data, 32'h12345678);
        // grant order from reset and masking
        do_reset();
        req_we = 0;
        for (int i = 0; i < 11; i++) begin
            arb_en = tbl[i].en;
            req_valid = tbl[i].v;
            for (int r = 0; r < 3; r++) req_addr[r*12 +: 12] = 12'(i + r);
            #1;
            chk("tbl_ready", req_ready, tbl[i].ready);
            step();
        end
        // reset with reads in flight drops them
        do_reset();
        set_req(0, 0, 0, 12'h010, 32'h0);
        set_req(1, 0, 0, 12'hA8F, 32'h0);
        step();
        step();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_no_rsp", rsp_valid, 1'b0);
        end
        // random traffic over a small address window so reads hit earlier writes
        for (int i = 0; i < 400; i++) begin
            arb_en = $urandom_range(0, 7) != 0;
            req_valid = 3'($urandom);
            req_we = 3'($urandom);
            req_bank = 6'($urandom);
            for (int r = 0; r < 3; r++) begin
                req_addr[r*12 +: 12] = 12'($urandom_range(0, 7));
                req_wdata[r*32 +: 32] = $urandom;
            end
            if (i == 200) do_reset();
            step();
        end
        req_valid = 0;
        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the single SRAM port (one CSn, per-bank active-low WEn, 12-bit Addr, 32-bit data, bank-0-only read path) among three requesters: image loader (0), convolution engine (1), weight loader (2). Round-robin arbitration, registered SRAM drive, tagged read returns. Sits directly between the requesters and the SRAM instance in the accelerator top.

## Interface
Parameters:
- NREQ, 3, number of requesters (fixed; ID width 2)
- ADDR_WIDTH, 12, SRAM address width
- DATA_WIDTH, 32, SRAM word width

Ports:
- CK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- arb_en  in  1  1 = grants allowed; 0 = no new grants, in-flight ops complete
- req_valid  in  NREQ  request valid, one bit per requester
- req_ready  out  NREQ  grant; handshake = valid & ready
- req_we  in  NREQ  1 = write, 0 = read
- req_bank  in  2*NREQ  target bank per requester (0 feature, 1 aux, 2 weight, 3 illegal)
- req_addr  in  ADDR_WIDTH*NREQ  word address per requester
- req_wdata  in  DATA_WIDTH*NREQ  write data per requester
- rsp_valid  out  1  read data valid
- rsp_id  out  2  requester ID of returned read
- rsp_data  out  DATA_WIDTH  read data
- err_bank  out  1  one-cycle pulse: accepted write to bank 3
- busy  out  1  1 while any op issued but not yet completed
- sram_csn  out  1  to SRAM CSn
- sram_wen  out  4  to SRAM WEn, active-low per bank
- sram_addr  out  ADDR_WIDTH  to SRAM Addr
- sram_din  out  DATA_WIDTH  to SRAM DataIn
- sram_dout  in  DATA_WIDTH  from SRAM DataOut

## Operation
- req_ready combinational: at most one bit high per cycle; only when arb_en=1 and that requester's req_valid=1.
- Round-robin: pointer p (reset 0). Search order p, p+1, p+2 mod 3; first valid wins. After a handshake by requester i, p <= (i+1) mod 3. No handshake: p holds.
- Accepted write, bank b in 0..2: next cycle sram_csn=0, sram_wen bit b = 0, others 1, addr/din from winner.
- Accepted write, bank 3: sram_csn=0, sram_wen=4'hF (no store), err_bank pulses same cycle as the issue stage.
- Accepted read: req_bank ignored (read path is bank 0 only); sram_csn=0, sram_wen=4'hF. Tag (id) pipelined two stages; rsp_valid/rsp_id from tag stage 2, rsp_data = sram_dout passthrough.
- No accept: sram_csn=1, sram_wen=4'hF, addr/din hold last value.
- No response backpressure; consumers must take rsp every cycle it is valid.
- busy = issue-stage valid | read-tag stage 1/2 valid.

## Timing
- Handshake in cycle T -> SRAM signals driven in T+1 (registered) -> SRAM samples at end of T+1 -> rsp_valid=1 in T+2 for reads.
- Read latency: 2 cycles from handshake; throughput 1 op/cycle, back-to-back mixed reads/writes legal.
- Write then read same address on consecutive accepts: read returns new data (SRAM write at edge precedes read edge).
- arb_en falling: accepts stop same cycle; ops already accepted complete normally.
- Reset values: req_ready=0, sram_csn=1, sram_wen=4'hF, sram_addr=0, sram_din=0, rsp_valid=0, rsp_id=0, err_bank=0, busy=0, p=0.
- RST mid-operation: all in-flight reads dropped, no rsp_valid after reset release until a new read is accepted.

## Structure
- Package sram_ctrl_pkg: BANK_FEAT=0, BANK_AUX=1, BANK_WGT=2, ID width 2, ADDR_WIDTH, DATA_WIDTH, REQ_LOADER/REQ_CONV/REQ_WLOAD ID constants.
- One sub-module: rr_arbiter3 (valid vector + pointer -> one-hot grant); the rest (issue register, tag pipeline) stays in sram_port_arbiter.

## Test plan
- Reset release, no requests -> sram_csn=1, sram_wen=4'hF, rsp_valid=0, busy=0.
- Req 2 writes bank 2 addr 0x010 data 0xDEADBEEF, then req 1 reads 0x010 -> read returns bank-0 value (0 after reset), sram_wen=4'b1011 on write cycle.
- Req 0 writes bank 0 addr 0xA8F data 0x12345678, next cycle req 1 reads 0xA8F -> rsp_valid at T+2, rsp_id=1, rsp_data=0x12345678.
- All three valid continuously for 6 cycles from reset -> grant order 0,1,2,0,1,2.
- Req 0 write bank 3 -> err_bank pulse, sram_wen=4'hF, no memory change.
- Two reads accepted, RST asserted before returns -> no rsp_valid after release; arb_en=0 with valids high -> req_ready=0.
